// File: rtl/pcs_sync_if.sv
// Receive-side code-group bus between the deserializer, the PCS sync block and the receive FSM.
// The master side feeds raw code-groups in and takes the qualified stream out; the slave is pcs_sync.
interface pcs_sync_if;
  logic       signal_detect;
  logic [9:0] rx_code_group;
  logic [9:0] SUDI;
  logic       rx_even;
  logic       code_sync_status;

  modport master (
    output signal_detect, rx_code_group,
    input  SUDI, rx_even, code_sync_status
  );

  modport slave (
    input  signal_detect, rx_code_group,
    output SUDI, rx_even, code_sync_status
  );
endinterface

// File: rtl/pcs_sync.sv
// 1000BASE-X PCS code-group synchronization: comma alignment, even/odd tracking and
// loss-of-sync hysteresis, with registered SUDI / rx_even / code_sync_status outputs.
module pcs_sync #(
  parameter int unsigned ACQ_COMMAS   = 3,
  parameter int unsigned GOOD_CGS_MAX = 3,
  parameter int unsigned BAD_LEVELS   = 4
) (
  input logic       GTX_CLK,
  input logic       mr_main_reset,
  pcs_sync_if.slave rx
);

  localparam int AW = $clog2(ACQ_COMMAS + 1);
  localparam int GW = $clog2(GOOD_CGS_MAX + 1);
  localparam int LW = $clog2(BAD_LEVELS + 1);

  localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_COMMAS);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_CGS_MAX);
  localparam logic [LW-1:0] LVL_LAST  = LW'(BAD_LEVELS);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);

  // Code-groups stored as {abcdei, fghj}; _N / _P are the RD- / RD+ encodings.
  localparam logic [9:0] K28_5_N = 10'h0FA, K28_5_P = 10'h305;
  localparam logic [9:0] K23_7_N = 10'h3A8, K23_7_P = 10'h057;
  localparam logic [9:0] K27_7_N = 10'h368, K27_7_P = 10'h097;
  localparam logic [9:0] K29_7_N = 10'h2E8, K29_7_P = 10'h117;
  localparam logic [9:0] D0_0_N  = 10'h274, D0_0_P  = 10'h18B;
  localparam logic [9:0] D1_0_N  = 10'h1D4, D1_0_P  = 10'h22B;
  localparam logic [9:0] D2_0_N  = 10'h2D4, D2_0_P  = 10'h12B;
  localparam logic [9:0] D3_0_N  = 10'h31B, D3_0_P  = 10'h314;
  localparam logic [9:0] D4_0_N  = 10'h354, D4_0_P  = 10'h0AB;
  localparam logic [9:0] D5_0_N  = 10'h29B, D5_0_P  = 10'h294;
  localparam logic [9:0] D6_0_N  = 10'h19B, D6_0_P  = 10'h194;
  localparam logic [9:0] D7_0_N  = 10'h38B, D7_0_P  = 10'h074;
  localparam logic [9:0] D5_6    = 10'h296;
  localparam logic [9:0] D16_2_N = 10'h1B5, D16_2_P = 10'h245;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT,
    ACQUIRE_SYNC,
    SYNC_ACQUIRED
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] acq_cnt, acq_cnt_n;
  logic [LW-1:0] level, level_n;
  logic [GW-1:0] good_cgs, good_cgs_n;
  logic          even_q, even_n;
  logic [9:0]    sudi_q;
  logic          status_q;

  logic valid, is_k, comma, data, cgbad;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid = 1'b1;
    is_k  = 1'b0;
    unique case (rx.rx_code_group)
      K28_5_N, K28_5_P, K23_7_N, K23_7_P,
      K27_7_N, K27_7_P, K29_7_N, K29_7_P: is_k = 1'b1;
      D0_0_N, D0_0_P, D1_0_N, D1_0_P, D2_0_N, D2_0_P, D3_0_N, D3_0_P,
      D4_0_N, D4_0_P, D5_0_N, D5_0_P, D6_0_N, D6_0_P, D7_0_N, D7_0_P,
      D5_6, D16_2_N, D16_2_P:             valid = 1'b1;
      default:                            valid = 1'b0;
    endcase
  end

  assign comma = (rx.rx_code_group == K28_5_N) || (rx.rx_code_group == K28_5_P);
  assign data  = valid && !is_k;
  // The toggled phase is ~even_q, so a comma is misaligned when even_q is currently 1.
  assign cgbad = !valid || (comma && even_q);

  always_comb begin
    state_n    = state;
    acq_cnt_n  = acq_cnt;
    level_n    = level;
    good_cgs_n = good_cgs;
    even_n     = ~even_q;
    if (!rx.signal_detect) begin
      state_n = LOSS_OF_SYNC;
    end else begin
      unique case (state)
        LOSS_OF_SYNC: if (comma) begin
          state_n   = COMMA_DETECT;
          acq_cnt_n = AW'(1);
          even_n    = 1'b1;
        end
        COMMA_DETECT: if (!data) begin
          state_n = LOSS_OF_SYNC;
        end else if (acq_cnt == ACQ_LAST) begin
          state_n    = SYNC_ACQUIRED;
          level_n    = LVL_ONE;
          good_cgs_n = '0;
        end else begin
          state_n = ACQUIRE_SYNC;
        end
        ACQUIRE_SYNC: if (comma && !even_q) begin
          state_n   = COMMA_DETECT;
          acq_cnt_n = acq_cnt + 1'b1;
        end else if (cgbad) begin
          state_n = LOSS_OF_SYNC;
        end
        SYNC_ACQUIRED: if (cgbad) begin
          // A bad code-group overrides any recovery the good counter would make this cycle.
          if (level == LVL_LAST) begin
            state_n = LOSS_OF_SYNC;
          end else begin
            level_n    = level + 1'b1;
            good_cgs_n = '0;
          end
        end else if (level != LVL_ONE) begin
          if ((good_cgs + 1'b1) == GOOD_LAST) begin
            level_n    = level - 1'b1;
            good_cgs_n = '0;
          end else begin
            good_cgs_n = good_cgs + 1'b1;
          end
        end
        default: state_n = LOSS_OF_SYNC;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state    <= LOSS_OF_SYNC;
      acq_cnt  <= '0;
      level    <= LVL_ONE;
      good_cgs <= '0;
      even_q   <= 1'b0;
      sudi_q   <= '0;
      status_q <= 1'b0;
    end else begin
      state    <= state_n;
      acq_cnt  <= acq_cnt_n;
      level    <= level_n;
      good_cgs <= good_cgs_n;
      even_q   <= even_n;
      sudi_q   <= rx.rx_code_group;
      status_q <= (state_n == SYNC_ACQUIRED);
    end
  end

  assign rx.SUDI             = sudi_q;
  assign rx.rx_even          = even_q;
  assign rx.code_sync_status = status_q;

endmodule
